// File: rtl/instruction_decode_queue_pkg.sv
// Shared types for the fetch-to-decode queue: decoded command layout,
// the stored fetch entry and RV64G major opcodes.
package instruction_decode_queue_pkg;

    typedef enum logic [4:0] {
        INVALID   = 5'd0,
        ADDI,
        ALU_IMM,
        ALU_IMM_W,
        ALU,
        ALU_W,
        LUI,
        AUIPC,
        JAL,
        JALR,
        BRANCH,
        LOAD,
        STORE,
        FENCE,
        SYSTEM,
        AMO,
        FP_LOAD,
        FP_STORE,
        FP_OP,
        FP_FMA
    } funct_t;

    typedef struct packed {
        funct_t      funct;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [2:0]  funct3;
        logic [63:0] imm;
    } decoded_instr_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] code;
    } fetch_entry_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FP_LOAD   = 7'b0000111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_FP_STORE  = 7'b0100111;
    localparam logic [6:0] OPC_AMO       = 7'b0101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_FMADD     = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB     = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB    = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD    = 7'b1001111;
    localparam logic [6:0] OPC_FP_OP     = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Compressed (16-bit) encodings have low bits other than 2'b11.
    function automatic logic is_compressed(input logic [31:0] code);
        return (code & 32'h3) != 32'h3;
    endfunction

endpackage

// File: rtl/instruction_decode_queue_decoder.sv
// Single-lane RV64G decoder: classifies the major opcode and extracts
// register fields and the sign-extended immediate. Unknown and compressed
// encodings produce an all-zero command, whose funct is INVALID.
module instruction_decoder
    import instruction_decode_queue_pkg::*;
(
    input  logic [31:0]    code_i,
    output decoded_instr_t cmd_o
);

    logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign i_imm = {{52{code_i[31]}}, code_i[31:20]};
    assign s_imm = {{52{code_i[31]}}, code_i[31:25], code_i[11:7]};
    assign b_imm = {{52{code_i[31]}}, code_i[7], code_i[30:25], code_i[11:8], 1'b0};
    assign u_imm = {{32{code_i[31]}}, code_i[31:12], 12'b0};
    assign j_imm = {{44{code_i[31]}}, code_i[19:12], code_i[20], code_i[30:21], 1'b0};

    // Decode by major opcode; fields a format does not use stay zero.
    always_comb begin
        cmd_o = '0;
        if (!is_compressed(code_i)) begin
            cmd_o.funct3 = code_i[14:12];
            case (code_i[6:0])
                OPC_OP_IMM: begin
                    cmd_o.funct = (code_i[14:12] == 3'b000) ? ADDI : ALU_IMM;
                    cmd_o.rd    = code_i[11:7];
                    cmd_o.rs1   = code_i[19:15];
                    cmd_o.imm   = i_imm;
                end
                OPC_OP_IMM_32, OPC_LOAD, OPC_FP_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                    case (code_i[6:0])
                        OPC_OP_IMM_32: cmd_o.funct = ALU_IMM_W;
                        OPC_LOAD:      cmd_o.funct = LOAD;
                        OPC_FP_LOAD:   cmd_o.funct = FP_LOAD;
                        OPC_JALR:      cmd_o.funct = JALR;
                        OPC_MISC_MEM:  cmd_o.funct = FENCE;
                        default:       cmd_o.funct = SYSTEM;
                    endcase
                    cmd_o.rd  = code_i[11:7];
                    cmd_o.rs1 = code_i[19:15];
                    cmd_o.imm = i_imm;
                end
                OPC_OP, OPC_OP_32, OPC_AMO, OPC_FP_OP: begin
                    case (code_i[6:0])
                        OPC_OP:    cmd_o.funct = ALU;
                        OPC_OP_32: cmd_o.funct = ALU_W;
                        OPC_AMO:   cmd_o.funct = AMO;
                        default:   cmd_o.funct = FP_OP;
                    endcase
                    cmd_o.rd  = code_i[11:7];
                    cmd_o.rs1 = code_i[19:15];
                    cmd_o.rs2 = code_i[24:20];
                    cmd_o.rs3 = code_i[31:27];
                end
                OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
                    cmd_o.funct = FP_FMA;
                    cmd_o.rd    = code_i[11:7];
                    cmd_o.rs1   = code_i[19:15];
                    cmd_o.rs2   = code_i[24:20];
                    cmd_o.rs3   = code_i[31:27];
                end
                OPC_STORE, OPC_FP_STORE: begin
                    cmd_o.funct = (code_i[6:0] == OPC_STORE) ? STORE : FP_STORE;
                    cmd_o.rs1   = code_i[19:15];
                    cmd_o.rs2   = code_i[24:20];
                    cmd_o.imm   = s_imm;
                end
                OPC_BRANCH: begin
                    cmd_o.funct = BRANCH;
                    cmd_o.rs1   = code_i[19:15];
                    cmd_o.rs2   = code_i[24:20];
                    cmd_o.imm   = b_imm;
                end
                OPC_LUI, OPC_AUIPC: begin
                    cmd_o.funct = (code_i[6:0] == OPC_LUI) ? LUI : AUIPC;
                    cmd_o.rd    = code_i[11:7];
                    cmd_o.imm   = u_imm;
                end
                OPC_JAL: begin
                    cmd_o.funct = JAL;
                    cmd_o.rd    = code_i[11:7];
                    cmd_o.imm   = j_imm;
                end
                default: cmd_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/instruction_decode_queue.sv
// Fetch-to-decode buffer: circular queue of {pc, code} entries with
// multi-word push from fetch, in-order multi-entry pop by issue, flush,
// and per-lane decode of the oldest NUM_LANES entries.
module instruction_decode_queue
    import instruction_decode_queue_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int NUM_LANES   = 2,
    parameter int DEPTH       = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  fetch_valid_i,
    output logic                                  fetch_ready_o,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0]      fetch_count_i,
    input  logic [63:0]                           fetch_pc_i,
    input  logic [FETCH_WIDTH*32-1:0]             fetch_code_i,
    output logic [NUM_LANES-1:0]                  dec_valid_o,
    output decoded_instr_t [NUM_LANES-1:0]        dec_cmd_o,
    output logic [NUM_LANES*64-1:0]               dec_pc_o,
    output logic [NUM_LANES-1:0]                  dec_illegal_o,
    input  logic [$clog2(NUM_LANES+1)-1:0]        dec_pop_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(FETCH_WIDTH + 1);

    fetch_entry_t storage [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] occupancy, free_slots, lanes_avail, pop_req, pop_eff;
    logic          count_ok, push_en;

    logic         wr_en    [FETCH_WIDTH];
    logic [AW-1:0] wr_addr [FETCH_WIDTH];
    fetch_entry_t wr_entry [FETCH_WIDTH];

    // The extra pointer bit distinguishes full from empty.
    assign occupancy  = wr_ptr - rd_ptr;
    assign free_slots = PW'(DEPTH) - occupancy;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign fetch_ready_o = rst_ni && (free_slots >= PW'(FETCH_WIDTH));
    assign count_ok      = (fetch_count_i != '0) && (fetch_count_i <= CW'(FETCH_WIDTH));
    assign push_en       = fetch_valid_i && fetch_ready_o && !flush_i && count_ok;

    // Clamp the requested pop to the number of lanes that actually hold entries.
    always_comb begin
        lanes_avail = (occupancy > PW'(NUM_LANES)) ? PW'(NUM_LANES) : occupancy;
        pop_req     = PW'(dec_pop_i);
        pop_eff     = (pop_req < lanes_avail) ? pop_req : lanes_avail;
    end

    // Per-word write slot, address and PC for the incoming packet.
    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            wr_en[k]         = push_en && (CW'(k) < fetch_count_i);
            wr_addr[k]       = AW'(wr_ptr + PW'(k));
            wr_entry[k].pc   = fetch_pc_i + 64'(4 * k);
            wr_entry[k].code = fetch_code_i[k*32 +: 32];
        end
    end

    // Entry storage is deliberately left unreset; pointers define validity.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (wr_en[k]) begin
                storage[wr_addr[k]] <= wr_entry[k];
            end
        end
    end

    // Pointer update: reset, then flush, then concurrent push and pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PW'(fetch_count_i);
            end
            rd_ptr <= rd_ptr + pop_eff;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic           lane_valid;
        logic [AW-1:0]  rd_addr;
        fetch_entry_t   entry;
        decoded_instr_t cmd;

        assign lane_valid = occupancy > PW'(k);
        assign rd_addr    = AW'(rd_ptr + PW'(k));
        assign entry      = storage[rd_addr];

        instruction_decoder u_decoder (
            .code_i (entry.code),
            .cmd_o  (cmd)
        );

        assign dec_valid_o[k]         = lane_valid;
        assign dec_cmd_o[k]           = lane_valid ? cmd : '0;
        assign dec_pc_o[k*64 +: 64]   = lane_valid ? entry.pc : 64'd0;
        assign dec_illegal_o[k]       = lane_valid && (cmd.funct == INVALID);
    end

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Directed testbench for instruction_decode_queue with default parameters
// (FETCH_WIDTH 2, NUM_LANES 2, DEPTH 8).
module tb_instruction_decode_queue;
    import instruction_decode_queue_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  flush_i;
    logic                  fetch_valid_i;
    logic                  fetch_ready_o;
    logic [1:0]            fetch_count_i;
    logic [63:0]           fetch_pc_i;
    logic [63:0]           fetch_code_i;
    logic [1:0]            dec_valid_o;
    decoded_instr_t [1:0]  dec_cmd_o;
    logic [127:0]          dec_pc_o;
    logic [1:0]            dec_illegal_o;
    logic [1:0]            dec_pop_i;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI5 = 32'h0050_0093;

    instruction_decode_queue dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_count_i (fetch_count_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_code_i  (fetch_code_i),
        .dec_valid_o   (dec_valid_o),
        .dec_cmd_o     (dec_cmd_o),
        .dec_pc_o      (dec_pc_o),
        .dec_illegal_o (dec_illegal_o),
        .dec_pop_i     (dec_pop_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1 ns past the edge.
    task automatic applyStimulus(input logic valid, input logic [1:0] count, input logic [63:0] pc,
                                 input logic [63:0] code, input logic [1:0] pop, input logic flush);
        fetch_valid_i = valid;
        fetch_count_i = count;
        fetch_pc_i    = pc;
        fetch_code_i  = code;
        dec_pop_i     = pop;
        flush_i       = flush;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic [63:0] next_pc;

        rst_ni = 1'b0;
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd0, 1'b0);
        checkOutput("rst_ready", 128'(fetch_ready_o), 128'(1'b0));
        checkOutput("rst_valid", 128'(dec_valid_o), 128'(2'b00));
        checkOutput("rst_illegal", 128'(dec_illegal_o), 128'(2'b00));
        checkOutput("rst_cmd", 128'(dec_cmd_o), 128'd0);
        checkOutput("rst_pc", dec_pc_o, 128'd0);
        rst_ni = 1'b1;
        #1;
        checkOutput("post_rst_ready", 128'(fetch_ready_o), 128'(1'b1));
        checkOutput("post_rst_valid", 128'(dec_valid_o), 128'(2'b00));

        $display("[TB] basic push");
        applyStimulus(1'b1, 2'd2, 64'h1000, {ADDI5, NOP}, 2'd0, 1'b0);
        checkOutput("push_valid", 128'(dec_valid_o), 128'(2'b11));
        checkOutput("push_funct0", 128'(dec_cmd_o[0].funct), 128'(ADDI));
        checkOutput("push_funct1", 128'(dec_cmd_o[1].funct), 128'(ADDI));
        checkOutput("push_rd1", 128'(dec_cmd_o[1].rd), 128'(5'd1));
        checkOutput("push_imm1", 128'(dec_cmd_o[1].imm), 128'(64'd5));
        checkOutput("push_pc", dec_pc_o, {64'h1004, 64'h1000});
        checkOutput("push_illegal", 128'(dec_illegal_o), 128'(2'b00));
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);
        checkOutput("pop_empty", 128'(dec_valid_o), 128'(2'b00));

        $display("[TB] capacity");
        applyStimulus(1'b1, 2'd2, 64'h2000, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("cap_ready1", 128'(fetch_ready_o), 128'(1'b1));
        applyStimulus(1'b1, 2'd2, 64'h2008, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("cap_ready2", 128'(fetch_ready_o), 128'(1'b1));
        applyStimulus(1'b1, 2'd2, 64'h2010, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("cap_ready3", 128'(fetch_ready_o), 128'(1'b1));
        applyStimulus(1'b1, 2'd2, 64'h2018, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("cap_ready4", 128'(fetch_ready_o), 128'(1'b0));
        applyStimulus(1'b1, 2'd2, 64'h2020, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("cap_ready5", 128'(fetch_ready_o), 128'(1'b0));
        checkOutput("cap_pc_full", dec_pc_o, {64'h2004, 64'h2000});
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);
        checkOutput("cap_ready_pop", 128'(fetch_ready_o), 128'(1'b1));
        checkOutput("cap_pc_a", dec_pc_o, {64'h200c, 64'h2008});
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);
        checkOutput("cap_pc_b", dec_pc_o, {64'h2014, 64'h2010});
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);
        checkOutput("cap_pc_c", dec_pc_o, {64'h201c, 64'h2018});
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);
        checkOutput("cap_drained", 128'(dec_valid_o), 128'(2'b00));

        $display("[TB] wrap-around");
        exp_pc  = 64'h3000;
        next_pc = 64'h3000;
        applyStimulus(1'b1, 2'd2, next_pc, {NOP, NOP}, 2'd0, 1'b0);
        next_pc = next_pc + 64'd8;
        for (int i = 0; i < 20; i++) begin
            checkOutput("wrap_valid", 128'(dec_valid_o), 128'(2'b11));
            checkOutput("wrap_pc", dec_pc_o, {exp_pc + 64'd4, exp_pc});
            exp_pc = exp_pc + 64'd8;
            applyStimulus(1'b1, 2'd2, next_pc, {NOP, NOP}, 2'd2, 1'b0);
            next_pc = next_pc + 64'd8;
        end
        checkOutput("wrap_last_pc", dec_pc_o, {exp_pc + 64'd4, exp_pc});
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);
        checkOutput("wrap_drained", 128'(dec_valid_o), 128'(2'b00));

        $display("[TB] illegal encodings");
        applyStimulus(1'b1, 2'd2, 64'h4000, {32'h0000_4501, 32'hFFFF_FFFF}, 2'd0, 1'b0);
        checkOutput("ill_valid", 128'(dec_valid_o), 128'(2'b11));
        checkOutput("ill_flags", 128'(dec_illegal_o), 128'(2'b11));
        checkOutput("ill_funct0", 128'(dec_cmd_o[0].funct), 128'(INVALID));
        checkOutput("ill_cmd1", 128'(dec_cmd_o[1]), 128'd0);
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);

        $display("[TB] flush");
        applyStimulus(1'b1, 2'd2, 64'h5000, {NOP, NOP}, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd2, 64'h5008, {NOP, NOP}, 2'd0, 1'b0);
        applyStimulus(1'b1, 2'd1, 64'h5010, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("pre_flush_pc", dec_pc_o, {64'h5004, 64'h5000});
        applyStimulus(1'b1, 2'd2, 64'h6000, {ADDI5, ADDI5}, 2'd2, 1'b1);
        checkOutput("flush_valid", 128'(dec_valid_o), 128'(2'b00));
        checkOutput("flush_ready", 128'(fetch_ready_o), 128'(1'b1));
        applyStimulus(1'b1, 2'd1, 64'h7000, {ADDI5, NOP}, 2'd0, 1'b0);
        checkOutput("post_flush_valid", 128'(dec_valid_o), 128'(2'b01));
        checkOutput("post_flush_pc", dec_pc_o, {64'h0, 64'h7000});

        $display("[TB] underflow and bad counts");
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd2, 1'b0);
        checkOutput("underflow_valid", 128'(dec_valid_o), 128'(2'b00));
        applyStimulus(1'b1, 2'd2, 64'h8000, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("after_underflow_pc", dec_pc_o, {64'h8004, 64'h8000});
        applyStimulus(1'b1, 2'd0, 64'h9000, {NOP, NOP}, 2'd2, 1'b0);
        checkOutput("count0_valid", 128'(dec_valid_o), 128'(2'b00));
        applyStimulus(1'b1, 2'd3, 64'h9000, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("count3_valid", 128'(dec_valid_o), 128'(2'b00));

        $display("[TB] partial pop");
        applyStimulus(1'b1, 2'd2, 64'hB000, {NOP, NOP}, 2'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd1, 1'b0);
        checkOutput("pop1_valid", 128'(dec_valid_o), 128'(2'b01));
        checkOutput("pop1_pc", dec_pc_o, {64'h0, 64'hB004});

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 2'd2, 64'hA000, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("pre_rst_valid", 128'(dec_valid_o), 128'(2'b11));
        rst_ni = 1'b0;
        applyStimulus(1'b1, 2'd2, 64'hC000, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("midrst_valid", 128'(dec_valid_o), 128'(2'b00));
        checkOutput("midrst_ready", 128'(fetch_ready_o), 128'(1'b0));
        checkOutput("midrst_pc", dec_pc_o, 128'd0);
        rst_ni = 1'b1;
        #1;
        checkOutput("midrst_release_ready", 128'(fetch_ready_o), 128'(1'b1));
        applyStimulus(1'b1, 2'd2, 64'hD000, {NOP, NOP}, 2'd0, 1'b0);
        checkOutput("after_rst_pc", dec_pc_o, {64'hD004, 64'hD000});
        applyStimulus(1'b0, 2'd0, 64'd0, 64'd0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
